t_descrambler: RTL



---
 rtl/t_descrambler.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/t_descrambler.sv
`default_nettype none
// ============================================================================
//  Module   : t_descrambler
//  Purpose  : Self-synchronizing ternary descrambler, d = s + 2*h2 + h5 (mod 3),
//             over a 5-trit history of received scrambled trits.
//             Optional frame check-trit strip/verify under T_DESCR_CHECKSUM_EN.
//  Revision : 1.0  initial release
// ============================================================================
module t_descrambler #(
    parameter int FRAME_LEN = 27
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] in_trit,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [1:0] out_trit,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       locked,
    output logic       code_err
`ifdef T_DESCR_CHECKSUM_EN
    ,
    output logic       chk_ok,
    output logic       chk_err
`endif
);

    localparam logic c_FILL = 1'b0;
    localparam logic c_RUN  = 1'b1;

    if (FRAME_LEN < 1) begin : g_bad_frame_len
        $error("t_descrambler: FRAME_LEN must be >= 1");
    end

    function automatic logic [1:0] mod3(input logic [2:0] v);
        logic [2:0] r;
        r = v;
        if (r >= 3'd6)      r = r - 3'd6;
        else if (r >= 3'd3) r = r - 3'd3;
        return r[1:0];
    endfunction

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic            r_state_q,     w_state_d;
    logic [2:0]      r_fill_cnt_q,  w_fill_cnt_d;
    logic [5:1][1:0] r_hist_q,      w_hist_d;
    logic [1:0]      r_out_trit_q,  w_out_trit_d;
    logic            r_out_valid_q, w_out_valid_d;
    logic            r_code_err_q,  w_code_err_d;

    logic            w_accept;
    logic            w_forward;
    logic [1:0]      w_s;
    logic [1:0]      w_neg_h2;
    logic [1:0]      w_d;

`ifdef T_DESCR_CHECKSUM_EN
    localparam int c_PH_W = $clog2(FRAME_LEN + 1);
    localparam logic [c_PH_W-1:0] c_CHK_PHASE = c_PH_W'(FRAME_LEN);

    logic [c_PH_W-1:0] r_phase_q,   w_phase_d;
    logic [1:0]        r_acc_q,     w_acc_d;
    logic              r_chk_ok_q,  w_chk_ok_d;
    logic              r_chk_err_q, w_chk_err_d;
`endif

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state_q <= c_FILL;
        else     r_state_q <= w_state_d;
    end

    // FSM: next state
    always_comb begin
        w_state_d = r_state_q;
        if (r_state_q == c_FILL && w_accept && r_fill_cnt_q == 3'd4)
            w_state_d = c_RUN;
    end

    // FSM: outputs
    always_comb begin
        locked = (r_state_q == c_RUN);
    end

    // ------------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------------
    assign in_ready = !r_out_valid_q || out_ready;
    assign w_accept = in_valid && in_ready;
    assign w_s      = (in_trit == 2'b11) ? 2'b00 : in_trit;

    // 2*h mod 3 equals -h mod 3, i.e. swap 1<->2; keeps the sum within 0..6.
    assign w_neg_h2 = {r_hist_q[2][0], r_hist_q[2][1]};
    assign w_d      = mod3({1'b0, w_s} + {1'b0, w_neg_h2} + {1'b0, r_hist_q[5]});

`ifdef T_DESCR_CHECKSUM_EN
    assign w_forward = (r_phase_q != c_CHK_PHASE);
`else
    assign w_forward = 1'b1;
`endif

    always_comb begin
        w_fill_cnt_d  = r_fill_cnt_q;
        w_hist_d      = r_hist_q;
        w_out_trit_d  = r_out_trit_q;
        w_out_valid_d = r_out_valid_q && !out_ready;
        w_code_err_d  = 1'b0;

        if (w_accept) begin
            w_hist_d     = {r_hist_q[4:1], w_s};
            w_code_err_d = (in_trit == 2'b11);
            if (r_state_q == c_FILL) begin
                w_fill_cnt_d = r_fill_cnt_q + 3'd1;
            end else if (w_forward) begin
                w_out_trit_d  = w_d;
                w_out_valid_d = 1'b1;
            end
        end
    end

`ifdef T_DESCR_CHECKSUM_EN
    // Payload trits accumulate; the check trit is compared, then the frame restarts.
    always_comb begin
        w_phase_d   = r_phase_q;
        w_acc_d     = r_acc_q;
        w_chk_ok_d  = 1'b0;
        w_chk_err_d = 1'b0;

        if (w_accept && r_state_q == c_RUN) begin
            if (r_phase_q == c_CHK_PHASE) begin
                w_chk_ok_d  = (w_d == r_acc_q);
                w_chk_err_d = (w_d != r_acc_q);
                w_phase_d   = '0;
                w_acc_d     = 2'b00;
            end else begin
                w_phase_d = r_phase_q + 1'b1;
                w_acc_d   = mod3({1'b0, r_acc_q} + {1'b0, w_d});
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase_q   <= '0;
            r_acc_q     <= 2'b00;
            r_chk_ok_q  <= 1'b0;
            r_chk_err_q <= 1'b0;
        end else begin
            r_phase_q   <= w_phase_d;
            r_acc_q     <= w_acc_d;
            r_chk_ok_q  <= w_chk_ok_d;
            r_chk_err_q <= w_chk_err_d;
        end
    end

    assign chk_ok  = r_chk_ok_q;
    assign chk_err = r_chk_err_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fill_cnt_q  <= 3'd0;
            r_hist_q      <= '0;
            r_out_trit_q  <= 2'b00;
            r_out_valid_q <= 1'b0;
            r_code_err_q  <= 1'b0;
        end else begin
            r_fill_cnt_q  <= w_fill_cnt_d;
            r_hist_q      <= w_hist_d;
            r_out_trit_q  <= w_out_trit_d;
            r_out_valid_q <= w_out_valid_d;
            r_code_err_q  <= w_code_err_d;
        end
    end

    assign out_trit  = r_out_trit_q;
    assign out_valid = r_out_valid_q;
    assign code_err  = r_code_err_q;

endmodule
`default_nettype wire
